// File: rtl/ysyx_22051013_pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_pipe_ctrl_pkg
//   Shared types for the pipeline controller: redirect-source encoding and
//   controller FSM states.
//   Source codes increase with stage age (NONE < ID < IE < LS), so "strictly
//   older" is a plain magnitude compare.
// ---------------------------------------------------------------------------
package ysyx_22051013_pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ID   = 2'd1,
      SRC_IE   = 2'd2,
      SRC_LS   = 2'd3
   } src_e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_REDIR = 1'b1
   } state_e;

endpackage

// File: rtl/ysyx_22051013_pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_pipe_ctrl_if
//   Redirect bus between the pipeline stages, the controller and fetch.
//   Signals:
//     id/ie/ls_redir   stage requests a redirect
//     id/ie/ls_target  requested target per stage
//     redir_valid      redirect offered to fetch (controller drives)
//     redir_pc         redirect target (controller drives)
//     redir_ready      fetch accepts the redirect this cycle
//   Modports:
//     master  controller side
//     slave   pipeline / fetch side
// ---------------------------------------------------------------------------
interface ysyx_22051013_pipe_ctrl_if #(
   parameter int unsigned PC_W = 64
);
   logic            id_redir;
   logic            ie_redir;
   logic            ls_redir;
   logic [PC_W-1:0] id_target;
   logic [PC_W-1:0] ie_target;
   logic [PC_W-1:0] ls_target;
   logic            redir_valid;
   logic [PC_W-1:0] redir_pc;
   logic            redir_ready;

   modport master (
      input  id_redir, ie_redir, ls_redir,
      input  id_target, ie_target, ls_target,
      input  redir_ready,
      output redir_valid, redir_pc
   );

   modport slave (
      output id_redir, ie_redir, ls_redir,
      output id_target, ie_target, ls_target,
      output redir_ready,
      input  redir_valid, redir_pc
   );
endinterface

// File: rtl/ysyx_22051013_hazard_det.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_hazard_det
//   Combinational load-use detector: the instruction in ID reads a register
//   that the load currently in IE has not produced yet. x0 never hazards.
//   Ports:
//     i_id_rs1/i_id_rs2        source registers of the ID instruction
//     i_id_use_rs1/i_id_use_rs2 ID instruction actually reads rs1/rs2
//     i_ie_rd                  destination register of the IE instruction
//     i_ie_is_load             IE instruction is a load
//     o_load_use               hazard present this cycle
// ---------------------------------------------------------------------------
module ysyx_22051013_hazard_det #(
   parameter int unsigned REG_W = 5
) (
   input  logic [REG_W-1:0] i_id_rs1,
   input  logic [REG_W-1:0] i_id_rs2,
   input  logic             i_id_use_rs1,
   input  logic             i_id_use_rs2,
   input  logic [REG_W-1:0] i_ie_rd,
   input  logic             i_ie_is_load,
   output logic             o_load_use
);
   logic w_hit_rs1;
   logic w_hit_rs2;

   assign w_hit_rs1  = i_id_use_rs1 && (i_id_rs1 == i_ie_rd);
   assign w_hit_rs2  = i_id_use_rs2 && (i_id_rs2 == i_ie_rd);
   assign o_load_use = i_ie_is_load && (i_ie_rd != '0) && (w_hit_rs1 || w_hit_rs2);
endmodule

// File: rtl/ysyx_22051013_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_pipe_ctrl
//   Hazard / sequencing controller for the IF-ID-IE-LS-WB pipeline.
//   Produces per-boundary stall/flush, arbitrates redirects (LS > IE > ID)
//   into one held redirect toward fetch, inserts load-use bubbles and counts
//   PC-stall cycles.
//   Ports:
//     clk, rst                 clock, async active-high reset
//     i_if_busy                fetch has no valid instruction
//     i_ls_busy                LS waits on memory, freeze everything
//     i_id_rs1/2, i_id_use_rs1/2, i_ie_rd, i_ie_is_load  load-use inputs
//     bus                      redirect bus (master side)
//     o_*_stall                hold boundary register / PC
//     o_*_flush                load bubble into boundary register
//     o_stall_cnt              cycles with o_pc_stall=1 (wraps)
// ---------------------------------------------------------------------------
module ysyx_22051013_pipe_ctrl
   import ysyx_22051013_pipe_ctrl_pkg::*;
#(
   parameter int unsigned PC_W  = 64,
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_if_busy,
   input  logic                      i_ls_busy,
   input  logic [REG_W-1:0]          i_id_rs1,
   input  logic [REG_W-1:0]          i_id_rs2,
   input  logic                      i_id_use_rs1,
   input  logic                      i_id_use_rs2,
   input  logic [REG_W-1:0]          i_ie_rd,
   input  logic                      i_ie_is_load,
   ysyx_22051013_pipe_ctrl_if.master bus,
   output logic                      o_pc_stall,
   output logic                      o_ifid_stall,
   output logic                      o_idie_stall,
   output logic                      o_iels_stall,
   output logic                      o_lswb_stall,
   output logic                      o_ifid_flush,
   output logic                      o_idie_flush,
   output logic                      o_iels_flush,
   output logic                      o_lswb_flush,
   output logic [CNT_W-1:0]          o_stall_cnt
);

   state_e          r_state;
   src_e            r_pend_src;
   logic [PC_W-1:0] r_redir_pc;
   logic [CNT_W-1:0] r_stall_cnt;

   state_e          w_state;
   src_e            w_pend_src;
   logic [PC_W-1:0] w_redir_pc;
   src_e            w_req_src;
   logic [PC_W-1:0] w_req_pc;
   logic            w_take;
   logic            w_load_use;

   ysyx_22051013_hazard_det #(
      .REG_W (REG_W)
   ) u_hazard_det (
      .i_id_rs1     (i_id_rs1),
      .i_id_rs2     (i_id_rs2),
      .i_id_use_rs1 (i_id_use_rs1),
      .i_id_use_rs2 (i_id_use_rs2),
      .i_ie_rd      (i_ie_rd),
      .i_ie_is_load (i_ie_is_load),
      .o_load_use   (w_load_use)
   );

   // Oldest requesting stage this cycle.
   always_comb begin
      w_req_src = SRC_NONE;
      w_req_pc  = '0;
      if (bus.ls_redir) begin
         w_req_src = SRC_LS;
         w_req_pc  = bus.ls_target;
      end else if (bus.ie_redir) begin
         w_req_src = SRC_IE;
         w_req_pc  = bus.ie_target;
      end else if (bus.id_redir) begin
         w_req_src = SRC_ID;
         w_req_pc  = bus.id_target;
      end
   end

   // r_pend_src is NONE in RUN, so one compare covers both a fresh redirect
   // and an older-stage replacement while one is pending.
   assign w_take = !i_ls_busy && (w_req_src > r_pend_src);

   always_comb begin
      w_state      = r_state;
      w_pend_src   = r_pend_src;
      w_redir_pc   = r_redir_pc;
      o_pc_stall   = 1'b0;
      o_ifid_stall = 1'b0;
      o_idie_stall = 1'b0;
      o_iels_stall = 1'b0;
      o_lswb_stall = 1'b0;
      o_ifid_flush = 1'b0;
      o_idie_flush = 1'b0;
      o_iels_flush = 1'b0;
      o_lswb_flush = 1'b0;

      // Replacement beats a same-cycle accept: the newer target must still
      // be offered.
      if (w_take) begin
         w_state    = ST_REDIR;
         w_pend_src = w_req_src;
         w_redir_pc = w_req_pc;
      end else if ((r_state == ST_REDIR) && bus.redir_ready) begin
         w_state    = ST_RUN;
         w_pend_src = SRC_NONE;
      end

      if (i_ls_busy) begin
         o_pc_stall   = 1'b1;
         o_ifid_stall = 1'b1;
         o_idie_stall = 1'b1;
         o_iels_stall = 1'b1;
         o_lswb_stall = 1'b1;
         o_lswb_flush = 1'b1;
      end else begin
         if (w_take) begin
            o_ifid_flush = 1'b1;
            o_idie_flush = (w_req_src >= SRC_IE);
            o_iels_flush = (w_req_src == SRC_LS);
         end
         if (r_state == ST_REDIR) begin
            o_ifid_flush = 1'b1;
         end else if (!w_take) begin
            if (w_load_use) begin
               o_pc_stall   = 1'b1;
               o_ifid_stall = 1'b1;
               o_idie_flush = 1'b1;
            end else if (i_if_busy) begin
               o_pc_stall   = 1'b1;
               o_ifid_flush = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_pend_src  <= SRC_NONE;
         r_redir_pc  <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state    <= w_state;
         r_pend_src <= w_pend_src;
         r_redir_pc <= w_redir_pc;
         if (o_pc_stall) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

   assign bus.redir_valid = (r_state == ST_REDIR);
   assign bus.redir_pc    = r_redir_pc;
   assign o_stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_ysyx_22051013_pipe_ctrl.sv
module tb_ysyx_22051013_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        if_busy;
   logic        ls_busy;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic [4:0]  ie_rd;
   logic        ie_is_load;
   logic        pc_stall, ifid_stall, idie_stall, iels_stall, lswb_stall;
   logic        ifid_flush, idie_flush, iels_flush, lswb_flush;
   logic [31:0] stall_cnt;
   logic [8:0]  ctl;

   ysyx_22051013_pipe_ctrl_if #(.PC_W(64)) bus ();

   ysyx_22051013_pipe_ctrl #(
      .PC_W  (64),
      .REG_W (5),
      .CNT_W (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_if_busy    (if_busy),
      .i_ls_busy    (ls_busy),
      .i_id_rs1     (id_rs1),
      .i_id_rs2     (id_rs2),
      .i_id_use_rs1 (id_use_rs1),
      .i_id_use_rs2 (id_use_rs2),
      .i_ie_rd      (ie_rd),
      .i_ie_is_load (ie_is_load),
      .bus          (bus),
      .o_pc_stall   (pc_stall),
      .o_ifid_stall (ifid_stall),
      .o_idie_stall (idie_stall),
      .o_iels_stall (iels_stall),
      .o_lswb_stall (lswb_stall),
      .o_ifid_flush (ifid_flush),
      .o_idie_flush (idie_flush),
      .o_iels_flush (iels_flush),
      .o_lswb_flush (lswb_flush),
      .o_stall_cnt  (stall_cnt)
   );

   // {pc, ifid, idie, iels, lswb stalls, ifid, idie, iels, lswb flushes}
   assign ctl = {pc_stall, ifid_stall, idie_stall, iels_stall, lswb_stall,
                 ifid_flush, idie_flush, iels_flush, lswb_flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Stage age: 0 none, 1 ID, 2 IE, 3 LS. A pending redirect from age A
   // accepts only requests of age > A.
   bit          m_pend;
   int          m_src;
   logic [63:0] m_pc;
   logic [31:0] m_inc;
   logic [31:0] m_base;
   logic [31:0] m_snap;

   int n_checks;
   int n_err;

   function automatic int req_age();
      if (bus.ls_redir) return 3;
      if (bus.ie_redir) return 2;
      if (bus.id_redir) return 1;
      return 0;
   endfunction

   function automatic logic [63:0] target_of(int age);
      case (age)
         3:       return bus.ls_target;
         2:       return bus.ie_target;
         default: return bus.id_target;
      endcase
   endfunction

   function automatic bit m_take();
      return !ls_busy && (req_age() > m_src);
   endfunction

   function automatic bit m_load_use();
      return ie_is_load && (ie_rd != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ie_rd) || (id_use_rs2 && id_rs2 == ie_rd));
   endfunction

   function automatic logic [8:0] exp_ctl();
      logic [8:0] v;
      int a;
      v = '0;
      if (ls_busy) begin
         v = 9'b11111_0001;
      end else begin
         a = req_age();
         // Winner of age a flushes the a youngest boundaries (ifid=bit3 ...).
         if (m_take())
            for (int k = 0; k < a; k++) v[3-k] = 1'b1;
         if (m_pend)
            v[3] = 1'b1;
         else if (!m_take() && m_load_use())
            v = v | 9'b11000_0100;
         else if (!m_take() && if_busy)
            v = v | 9'b10000_1000;
      end
      return v;
   endfunction

   function automatic logic [31:0] exp_cnt();
      return m_base + (m_inc - m_snap);
   endfunction

   always @(posedge clk or posedge rst) begin : model_upd
      logic [8:0] c;
      if (rst) begin
         m_pend <= 1'b0;
         m_src  <= 0;
         m_pc   <= '0;
         m_inc  <= '0;
      end else begin
         c = exp_ctl();
         if (c[8]) m_inc <= m_inc + 32'd1;
         if (m_take()) begin
            m_pend <= 1'b1;
            m_src  <= req_age();
            m_pc   <= target_of(req_age());
         end else if (m_pend && bus.redir_ready) begin
            m_pend <= 1'b0;
            m_src  <= 0;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      if (rst) return;
      check("model_ctl", {55'd0, ctl}, {55'd0, exp_ctl()});
      check("model_redir_valid", {63'd0, bus.redir_valid}, {63'd0, m_pend});
      if (m_pend) check("model_redir_pc", bus.redir_pc, m_pc);
      check("model_stall_cnt", {32'd0, stall_cnt}, {32'd0, exp_cnt()});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
      compare_model();
   endtask

   task automatic set_idle();
      if_busy = 0; ls_busy = 0;
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ie_rd = 0; ie_is_load = 0;
      bus.id_redir = 0; bus.ie_redir = 0; bus.ls_redir = 0;
      bus.id_target = '0; bus.ie_target = '0; bus.ls_target = '0;
      bus.redir_ready = 0;
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      m_base   = '0;
      m_snap   = '0;
      rst = 1'b1;
      set_idle();

      // Reset state
      @(negedge clk);
      check("rst_valid", {63'd0, bus.redir_valid}, 64'd0);
      check("rst_ctl", {55'd0, ctl}, 64'd0);
      check("rst_cnt", {32'd0, stall_cnt}, 64'd0);
      tick();
      rst = 1'b0;

      // 1. Load-use
      ie_is_load = 1; ie_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
      look();
      check("lu_ctl", {55'd0, ctl}, {55'd0, 9'b11000_0100});
      tick();
      set_idle();
      look();
      check("lu_after", {55'd0, ctl}, 64'd0);
      tick();
      ie_is_load = 1; ie_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1;
      look();
      check("lu_x0", {55'd0, ctl}, 64'd0);
      tick();
      set_idle();

      // 2. IE redirect with held ready
      bus.ie_redir = 1; bus.ie_target = 64'h8000_0040;
      look();
      check("ie_flush", {55'd0, ctl}, {55'd0, 9'b00000_1100});
      check("ie_v0", {63'd0, bus.redir_valid}, 64'd0);
      tick();
      bus.ie_redir = 0; bus.redir_ready = 0;
      for (int i = 0; i < 3; i++) begin
         look();
         check("redir_hold_v", {63'd0, bus.redir_valid}, 64'd1);
         check("redir_hold_pc", bus.redir_pc, 64'h8000_0040);
         check("redir_hold_ctl", {55'd0, ctl}, {55'd0, 9'b00000_1000});
         tick();
      end
      bus.redir_ready = 1;
      look();
      check("accept_v", {63'd0, bus.redir_valid}, 64'd1);
      tick();
      bus.redir_ready = 0;
      look();
      check("back_run_v", {63'd0, bus.redir_valid}, 64'd0);
      check("back_run_ctl", {55'd0, ctl}, 64'd0);

      // 3. Replacement by older stage, younger ignored
      tick();
      bus.ie_redir = 1; bus.ie_target = 64'h8000_0080;
      look();
      tick();
      bus.ie_redir = 0; bus.id_redir = 1; bus.id_target = 64'h1234;
      look();
      check("id_ignored_ctl", {55'd0, ctl}, {55'd0, 9'b00000_1000});
      check("id_ignored_pc", bus.redir_pc, 64'h8000_0080);
      tick();
      bus.id_redir = 0; bus.ls_redir = 1; bus.ls_target = 64'h8000_0100;
      look();
      check("ls_replace_ctl", {55'd0, ctl}, {55'd0, 9'b00000_1110});
      tick();
      bus.ls_redir = 0;
      look();
      check("ls_replace_pc", bus.redir_pc, 64'h8000_0100);
      tick();
      bus.redir_ready = 1;
      look();
      tick();
      bus.redir_ready = 0;
      look();
      check("t3_run_v", {63'd0, bus.redir_valid}, 64'd0);

      // 4. ls_busy freeze with held id_redir
      tick();
      ls_busy = 1; bus.id_redir = 1; bus.id_target = 64'h2000;
      for (int i = 0; i < 4; i++) begin
         look();
         check("lsbusy_ctl", {55'd0, ctl}, {55'd0, 9'b11111_0001});
         check("lsbusy_v", {63'd0, bus.redir_valid}, 64'd0);
         tick();
      end
      ls_busy = 0;
      look();
      check("post_busy_ctl", {55'd0, ctl}, {55'd0, 9'b00000_1000});
      tick();
      bus.id_redir = 0;
      look();
      check("post_busy_v", {63'd0, bus.redir_valid}, 64'd1);
      check("post_busy_pc", bus.redir_pc, 64'h2000);
      check("cnt_five", {32'd0, stall_cnt}, 64'd5);
      tick();
      bus.redir_ready = 1;
      look();
      tick();
      bus.redir_ready = 0;
      look();

      // 5. Async reset mid-redirect
      tick();
      bus.ie_redir = 1; bus.ie_target = 64'h8000_0040;
      look();
      tick();
      bus.ie_redir = 0;
      look();
      check("pre_rst_v", {63'd0, bus.redir_valid}, 64'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_v", {63'd0, bus.redir_valid}, 64'd0);
      check("async_rst_ctl", {55'd0, ctl}, 64'd0);
      check("async_rst_cnt", {32'd0, stall_cnt}, 64'd0);
      tick();
      rst = 1'b0;
      look();
      check("post_rst_v", {63'd0, bus.redir_valid}, 64'd0);

      // 6. Counter wrap
      #1;
      force dut.r_stall_cnt = 32'hFFFF_FFFE;
      m_base = 32'hFFFF_FFFE;
      m_snap = m_inc;
      #1;
      release dut.r_stall_cnt;
      tick();
      if_busy = 1;
      look();
      check("cnt_preload", {32'd0, stall_cnt}, 64'hFFFF_FFFE);
      tick();
      tick();
      look();
      check("cnt_wrap", {32'd0, stall_cnt}, 64'd0);
      tick();
      set_idle();

      // Random stimulus against the model
      for (int i = 0; i < 400; i++) begin
         ls_busy       = ($urandom_range(0, 5) == 0);
         if_busy       = ($urandom_range(0, 3) == 0);
         id_rs1        = 5'($urandom_range(0, 3));
         id_rs2        = 5'($urandom_range(0, 3));
         id_use_rs1    = 1'($urandom_range(0, 1));
         id_use_rs2    = 1'($urandom_range(0, 1));
         ie_rd         = 5'($urandom_range(0, 3));
         ie_is_load    = 1'($urandom_range(0, 1));
         bus.id_redir  = ($urandom_range(0, 7) == 0);
         bus.ie_redir  = ($urandom_range(0, 7) == 0);
         bus.ls_redir  = ($urandom_range(0, 9) == 0);
         bus.id_target = {$urandom, $urandom};
         bus.ie_target = {$urandom, $urandom};
         bus.ls_target = {$urandom, $urandom};
         bus.redir_ready = 1'($urandom_range(0, 1));
         look();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
